// File: rtl/twiddle_trivial_r22.sv
// twiddle_trivial_r22
// Trivial-twiddle stage for radix-2^2 single-path delay-feedback FFT pipelines.
// A passes straight through. B is rotated by -j (INVERSE=0) or +j (INVERSE=1)
// for the second half of every frame of 2^LOG2P pairs. Output is registered,
// with one ce-qualified cycle of latency.
//
// Parameters:
//   WIDTH   two's-complement width of each real/imag component
//   LOG2P   log2 of pairs per frame (1..12)
//   INVERSE 0: rotate by -j, 1: rotate by +j
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ce                  clock enable, all state holds when low
//   valid_i, sof_i      input pair valid, first pair of a frame
//   ar, ai, br, bi      signed input pair
//   valid_o             output pair valid
//   sof_o, last_o       output pair is frame index 0 / index 2^LOG2P-1
//   rot_o               B was rotated for this pair
//   ovf_o               a negation saturated on this pair (saturating build only)
//   xr, xi, yr, yi      signed output pair
//
// Build option: define TWIDDLE_TRIVIAL_R22_SAT_EN to saturate the negation of
// the most negative value and report it on ovf_o. Without it the negation
// wraps and ovf_o is tied low.

module twiddle_trivial_r22 #(
  parameter int WIDTH   = 8,
  parameter int LOG2P   = 1,
  parameter int INVERSE = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic                    valid_i,
  input  logic                    sof_i,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  output logic                    valid_o,
  output logic                    sof_o,
  output logic                    last_o,
  output logic                    rot_o,
  output logic                    ovf_o,
  output logic signed [WIDTH-1:0] xr,
  output logic signed [WIDTH-1:0] xi,
  output logic signed [WIDTH-1:0] yr,
  output logic signed [WIDTH-1:0] yi
);

`ifdef TWIDDLE_TRIVIAL_R22_SAT_EN
  localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  function automatic logic signed [WIDTH-1:0] f_neg(input logic signed [WIDTH-1:0] v);
`ifdef TWIDDLE_TRIVIAL_R22_SAT_EN
    if (v == C_MIN) return C_MAX;
    return -v;
`else
    return -v;
`endif
  endfunction

  logic [LOG2P-1:0]        r_k;
  logic [LOG2P-1:0]        w_idx;
  logic                    w_start;
  logic                    w_rot;
  logic                    w_first;
  logic                    w_last;
  logic signed [WIDTH-1:0] w_neg_br;
  logic signed [WIDTH-1:0] w_neg_bi;
  logic signed [WIDTH-1:0] w_yr;
  logic signed [WIDTH-1:0] w_yi;

  logic                    r_valid;
  logic                    r_sof;
  logic                    r_last;
  logic                    r_rot;
  logic signed [WIDTH-1:0] r_xr;
  logic signed [WIDTH-1:0] r_xi;
  logic signed [WIDTH-1:0] r_yr;
  logic signed [WIDTH-1:0] r_yi;

  // sof_i forces index 0 regardless of where k is, including on a wrap.
  assign w_start = valid_i & sof_i;
  assign w_idx   = w_start ? '0 : r_k;

  // Markers are qualified by valid_i so an invalid cycle forces rot=0.
  assign w_rot   = valid_i & w_idx[LOG2P-1];
  assign w_first = valid_i & (w_idx == '0);
  assign w_last  = valid_i & (w_idx == '1);

  assign w_neg_br = f_neg(br);
  assign w_neg_bi = f_neg(bi);

  always_comb begin
    w_yr = br;
    w_yi = bi;
    if (w_rot) begin
      if (INVERSE == 0) begin
        w_yr = bi;
        w_yi = w_neg_br;
      end else begin
        w_yr = w_neg_bi;
        w_yi = br;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_k     <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_last  <= 1'b0;
      r_rot   <= 1'b0;
      r_xr    <= '0;
      r_xi    <= '0;
      r_yr    <= '0;
      r_yi    <= '0;
    end else if (ce) begin
      // Index 0 on sof_i makes k load 1, otherwise k steps and wraps.
      if (valid_i) r_k <= w_idx + LOG2P'(1);
      r_valid <= valid_i;
      r_sof   <= w_first;
      r_last  <= w_last;
      r_rot   <= w_rot;
      r_xr    <= ar;
      r_xi    <= ai;
      r_yr    <= w_yr;
      r_yi    <= w_yi;
    end
  end

`ifdef TWIDDLE_TRIVIAL_R22_SAT_EN
  logic w_ovf;
  logic r_ovf;

  // Only the component that gets negated can saturate.
  assign w_ovf = w_rot & ((INVERSE == 0) ? (br == C_MIN) : (bi == C_MIN));

  always_ff @(posedge CLK) begin
    if (RST)     r_ovf <= 1'b0;
    else if (ce) r_ovf <= w_ovf;
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = 1'b0;
`endif

  assign valid_o = r_valid;
  assign sof_o   = r_sof;
  assign last_o  = r_last;
  assign rot_o   = r_rot;
  assign xr      = r_xr;
  assign xi      = r_xi;
  assign yr      = r_yr;
  assign yi      = r_yi;

endmodule

// File: tb/tb_twiddle_trivial_r22.sv
module tb_twiddle_trivial_r22;

  logic CLK = 1'b0;
  logic RST, ce, valid_i, sof_i;
  logic signed [7:0] ar, ai, br, bi;

  logic v0, s0, l0, r0, ov0;
  logic v1, s1, l1, r1, ov1;
  logic signed [7:0] xr0, xi0, yr0, yi0;
  logic signed [7:0] xr1, xi1, yr1, yi1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  twiddle_trivial_r22 #(.WIDTH(8), .LOG2P(2), .INVERSE(0)) dut0 (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .sof_i(sof_i),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .valid_o(v0), .sof_o(s0), .last_o(l0), .rot_o(r0), .ovf_o(ov0),
    .xr(xr0), .xi(xi0), .yr(yr0), .yi(yi0)
  );

  twiddle_trivial_r22 #(.WIDTH(8), .LOG2P(2), .INVERSE(1)) dut1 (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .sof_i(sof_i),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .valid_o(v1), .sof_o(s1), .last_o(l1), .rot_o(r1), .ovf_o(ov1),
    .xr(xr1), .xi(xi1), .yr(yr1), .yi(yi1)
  );

  // flags = {valid, sof, last, rot, ovf}
  wire [4:0]  f0 = {v0, s0, l0, r0, ov0};
  wire [4:0]  f1 = {v1, s1, l1, r1, ov1};
  wire [15:0] x0 = {xr0, xi0};
  wire [15:0] x1 = {xr1, xi1};
  wire [15:0] y0 = {yr0, yi0};
  wire [15:0] y1 = {yr1, yi1};

`ifdef TWIDDLE_TRIVIAL_R22_SAT_EN
  localparam logic [7:0] NEG_MIN = 8'h7F;
  localparam logic       SAT     = 1'b1;
`else
  localparam logic [7:0] NEG_MIN = 8'h80;
  localparam logic       SAT     = 1'b0;
`endif

  task automatic drive(input logic c, input logic v, input logic s,
                       input logic signed [7:0] a_r, input logic signed [7:0] a_i,
                       input logic signed [7:0] b_r, input logic signed [7:0] b_i);
    ce = c; valid_i = v; sof_i = s; ar = a_r; ai = a_i; br = b_r; bi = b_i;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive(1, 1, 1, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    drive(1, 1, 1, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    RST = 1'b0;
    if (f0 !== 5'b0) begin errors++; $display("FAIL reset_flags0 got %b want %b", f0, 5'b0); end
    checks++;
    if (f1 !== 5'b0) begin errors++; $display("FAIL reset_flags1 got %b want %b", f1, 5'b0); end
    checks++;
    if ({x0, y0, y1} !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", {x0, y0, y1}); end
    checks++;
  endtask

  task automatic test_frame;
    logic [7:0]  rot_tab;
    logic [4:0]  ef;
    logic [15:0] ey0, ey1, ex;
    logic        rot;
    rot_tab = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, (i == 0), 8'(i), 8'(i + 16), 8'sd10, 8'sd3);
      rot = rot_tab[i];
      ef  = {1'b1, (i % 4 == 0), (i % 4 == 3), rot, 1'b0};
      ex  = {8'(i), 8'(i + 16)};
      ey0 = rot ? {8'sd3, -8'sd10} : {8'sd10, 8'sd3};
      ey1 = rot ? {-8'sd3, 8'sd10} : {8'sd10, 8'sd3};
      if (f0 !== ef) begin errors++; $display("FAIL frame_flags0[%0d] got %b want %b", i, f0, ef); end
      checks++;
      if (f1 !== ef) begin errors++; $display("FAIL frame_flags1[%0d] got %b want %b", i, f1, ef); end
      checks++;
      if (y0 !== ey0) begin errors++; $display("FAIL frame_y0[%0d] got %h want %h", i, y0, ey0); end
      checks++;
      if (y1 !== ey1) begin errors++; $display("FAIL frame_y1[%0d] got %h want %h", i, y1, ey1); end
      checks++;
      if (x0 !== ex || x1 !== ex) begin errors++; $display("FAIL frame_x[%0d] got %h/%h want %h", i, x0, x1, ex); end
      checks++;
    end
  endtask

  task automatic test_gaps_ce;
    drive(1, 1, 1, 8'sd1, 8'sd1, 8'sd1, 8'sd2);
    if (f0 !== 5'b11000 || y0 !== {8'sd1, 8'sd2}) begin errors++; $display("FAIL gap_p0 got %b %h want 11000 0102", f0, y0); end
    checks++;
    drive(1, 0, 0, 8'sd0, 8'sd0, 8'sd9, 8'sd9);
    if (f0 !== 5'b0 || f1 !== 5'b0) begin errors++; $display("FAIL gap_invalid got %b/%b want 00000", f0, f1); end
    checks++;
    drive(1, 1, 0, 8'sd2, 8'sd2, 8'sd4, 8'sd5);
    if (f0 !== 5'b10000 || y0 !== {8'sd4, 8'sd5}) begin errors++; $display("FAIL gap_p1 got %b %h want 10000 0405", f0, y0); end
    checks++;
    drive(0, 1, 1, 8'sd7, 8'sd7, 8'sd7, 8'sd7);
    if (f0 !== 5'b10000 || y0 !== {8'sd4, 8'sd5} || x0 !== {8'sd2, 8'sd2}) begin errors++; $display("FAIL ce_hold1 got %b %h %h want 10000 0405 0202", f0, y0, x0); end
    checks++;
    drive(0, 0, 0, 8'sd7, 8'sd7, 8'sd7, 8'sd7);
    if (f0 !== 5'b10000 || y0 !== {8'sd4, 8'sd5}) begin errors++; $display("FAIL ce_hold2 got %b %h want 10000 0405", f0, y0); end
    checks++;
    drive(1, 1, 0, 8'sd3, 8'sd3, 8'sd6, 8'sd8);
    if (f0 !== 5'b10010 || y0 !== {8'sd8, -8'sd6} || y1 !== {-8'sd8, 8'sd6}) begin errors++; $display("FAIL gap_p2 got %b %h %h want 10010 08fa f806", f0, y0, y1); end
    checks++;
    drive(1, 0, 1, 8'sd0, 8'sd0, 8'sd6, 8'sd8);
    if (f0 !== 5'b0 || y0 !== {8'sd6, 8'sd8}) begin errors++; $display("FAIL gap_sof_ignored got %b %h want 00000 0608", f0, y0); end
    checks++;
    drive(1, 1, 0, 8'sd4, 8'sd4, 8'sd6, 8'sd8);
    if (f0 !== 5'b10110) begin errors++; $display("FAIL gap_p3 got %b want 10110", f0); end
    checks++;
    drive(1, 1, 0, 8'sd5, 8'sd5, 8'sd1, 8'sd1);
    if (f0 !== 5'b11000) begin errors++; $display("FAIL gap_wrap got %b want 11000", f0); end
    checks++;
  endtask

  task automatic test_sof_realign;
    logic [4:0] ef [7];
    // sof at idx 0, then idx 1 carries sof again, 1,2,3, then sof at idx 3 slot.
    ef = '{5'b11000, 5'b11000, 5'b10000, 5'b10010, 5'b10110, 5'b11000, 5'b10000};
    drive(1, 1, 1, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    if (f0 !== ef[0]) begin errors++; $display("FAIL sof_p0 got %b want %b", f0, ef[0]); end
    checks++;
    drive(1, 1, 1, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    if (f0 !== ef[1]) begin errors++; $display("FAIL sof_realign got %b want %b", f0, ef[1]); end
    checks++;
    for (int i = 2; i < 5; i++) begin
      drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
      if (f0 !== ef[i]) begin errors++; $display("FAIL sof_follow[%0d] got %b want %b", i, f0, ef[i]); end
      checks++;
    end
    drive(1, 1, 1, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    if (f0 !== ef[5]) begin errors++; $display("FAIL sof_after_last got %b want %b", f0, ef[5]); end
    checks++;
    drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    // idx 2 reached; sof in the idx-3 slot must suppress last_o
    drive(1, 1, 1, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    if (f0 !== ef[5]) begin errors++; $display("FAIL sof_abort_nolast got %b want %b", f0, ef[5]); end
    checks++;
    drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd10, 8'sd3);
    if (f0 !== ef[6]) begin errors++; $display("FAIL sof_abort_next got %b want %b", f0, ef[6]); end
    checks++;
  endtask

  task automatic test_reset_mid;
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    RST = 1'b1;
    drive(0, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    RST = 1'b0;
    if ({f0, f1} !== 10'b0 || {x0, y0, y1} !== 48'h0) begin errors++; $display("FAIL rst_mid got %b %b %h want all 0", f0, f1, {x0, y0, y1}); end
    checks++;
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    if (f0 !== 5'b11000) begin errors++; $display("FAIL rst_first_idx0 got %b want 11000", f0); end
    checks++;
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
    if (f0 !== 5'b10010) begin errors++; $display("FAIL rst_idx2 got %b want 10010", f0); end
    checks++;
    drive(1, 1, 0, 8'sd1, 8'sd1, 8'sd10, 8'sd3);
  endtask

  task automatic test_saturation;
    drive(1, 1, 1, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    drive(1, 1, 0, 8'sd0, 8'sd0, 8'sd0, -8'sd128);
    if (y1 !== {NEG_MIN, 8'sd0} || ov1 !== SAT) begin errors++; $display("FAIL sat_inv_bi got %h ovf %b want %h ovf %b", y1, ov1, {NEG_MIN, 8'sd0}, SAT); end
    checks++;
    if (y0 !== {-8'sd128, 8'sd0} || ov0 !== 1'b0) begin errors++; $display("FAIL sat_fwd_bi got %h ovf %b want 8000 ovf 0", y0, ov0); end
    checks++;
    drive(1, 1, 0, 8'sd0, 8'sd0, -8'sd128, 8'sd5);
    if (y0 !== {8'sd5, NEG_MIN} || ov0 !== SAT) begin errors++; $display("FAIL sat_fwd_br got %h ovf %b want %h ovf %b", y0, ov0, {8'sd5, NEG_MIN}, SAT); end
    checks++;
    if (y1 !== {-8'sd5, -8'sd128} || ov1 !== 1'b0) begin errors++; $display("FAIL sat_inv_br got %h ovf %b want fb80 ovf 0", y1, ov1); end
    checks++;
    // unrotated pair with the most negative value never flags overflow
    drive(1, 1, 0, 8'sd0, 8'sd0, -8'sd128, -8'sd128);
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || y0 !== 16'h8080) begin errors++; $display("FAIL sat_unrot got %b%b %h want 00 8080", ov0, ov1, y0); end
    checks++;
  endtask

  initial begin
    RST = 1'b0; ce = 1'b0; valid_i = 1'b0; sof_i = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    test_reset;
    test_frame;
    test_gaps_ce;
    test_sof_realign;
    test_reset_mid;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twiddle_trivial_r22.md
# twiddle_trivial_r22

Parametrised trivial-twiddle stage for radix-2² single-path delay-feedback FFT pipelines, the generalised successor of the fixed 4-point −j rotator. It sits between a butterfly pair and the next butterfly. Input A passes through unchanged. Input B is rotated by −j (or +j when inverse) for the second half of each frame of 2^LOG2P pairs. A frame-start input realigns the internal pair counter, and frame markers are carried to the output with the data.

## Interface
- WIDTH, 8: two's-complement width of each real/imag component.
- LOG2P, 1: log2 of pairs per frame; range 1..12. LOG2P=1 gives the plain 4-point 1/−j alternation.
- INVERSE, 0: 0 rotates by −j; 1 rotates by +j.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- valid_i  in  1  input pair valid.
- sof_i  in  1  first pair of a frame; qualified by valid_i.
- ar, ai, br, bi  in  WIDTH each  signed input pair.
- valid_o  out  1  output pair valid.
- sof_o  out  1  output pair is frame index 0.
- last_o  out  1  output pair is frame index 2^LOG2P−1.
- rot_o  out  1  B was rotated for this output pair.
- ovf_o  out  1  negation saturated this pair; see Configuration.
- xr, xi, yr, yi  out  WIDTH each  signed output pair.

## Operation
- Pair counter k is LOG2P bits wide. It advances only on a cycle where ce is high and valid_i is high.
- Effective index: when valid_i and sof_i are both high, the index is 0 and k loads 1. Otherwise the index is k and k increments, wrapping from 2^LOG2P−1 to 0.
- Rotate condition: rot = the MSB of the effective index, i.e. index ≥ 2^(LOG2P−1).
- X path: xr=ar, xi=ai, always.
- Y path when rot=0: yr=br, yi=bi.
- Y path when rot=1 and INVERSE=0: yr=bi, yi=−br.
- Y path when rot=1 and INVERSE=1: yr=−bi, yi=br.
- Negation is WIDTH-bit. Overflow behaviour for −2^(WIDTH−1) is set by Configuration.
- Invalid cycle (ce=1, valid_i=0):
  - k holds.
  - valid_o, sof_o, last_o, rot_o and ovf_o go to 0.
  - Data outputs take the computed values with rot=0 forced; downstream ignores them.
- sof_i while valid_i=0 is ignored.
- A mid-frame sof_i aborts the current frame. No last_o is emitted for the truncated frame.

## Timing
- Latency is 1 ce-qualified cycle from a valid input pair to valid_o with its data and markers.
- Throughput is one pair per clock. There is no backpressure.
- ce low: all registers hold, including k and every output. valid_o keeps its value; downstream qualifies it with ce.
- RST high: on the next edge, k=0 and every output is 0 (valid_o, sof_o, last_o, rot_o, ovf_o, xr, xi, yr, yi).
- RST takes priority over ce and valid_i.
- Reset mid-frame discards the partial frame. The first valid pair after reset is index 0 even without sof_i.
- Simultaneous sof_i and wrap: sof_i wins. The index is 0 and k loads 1.
- last_o is asserted exactly when the effective index = 2^LOG2P−1. This holds even if the next pair carries sof_i.

## Configuration
- Macro: TWIDDLE_TRIVIAL_R22_SAT_EN.
- Defined:
  - Negating −2^(WIDTH−1) yields 2^(WIDTH−1)−1.
  - ovf_o is registered with the data. It is 1 for a valid rotated pair where a negation saturated.
- Undefined:
  - Negation wraps, so −(−2^(WIDTH−1)) stays −2^(WIDTH−1).
  - ovf_o is constant 0.
- All other behaviour is identical in both builds.

## Test plan
- WIDTH=8, LOG2P=2, INVERSE=0.
  - Stimulus: reset, then 8 consecutive valid pairs with b=(10,3) and sof_i on pair 0.
  - Required: rot_o is 0,0,1,1,0,0,1,1.
  - Required: y=(10,3) when unrotated and (3,−10) when rotated.
  - Required: sof_o on outputs 1 and 5; last_o on outputs 4 and 8; each 1 cycle after its input.
- INVERSE=1, same stimulus.
  - Required: rotated y=(−3,10); x always equals a.
- Gaps and ce.
  - Stimulus: insert valid_i=0 gaps and ce=0 stalls between pairs.
  - Required: index sequence unchanged.
  - Required: outputs frozen during ce=0; valid_o=0 on the cycle after each gap.
- sof_i realignment.
  - Stimulus: assert sof_i on index 1 of a frame.
  - Required: that pair has rot_o=0 and sof_o=1; the following pairs are indices 1,2,3.
  - Required: no last_o for the aborted frame.
- Reset mid-frame.
  - Stimulus: assert RST after 3 pairs.
  - Required: all outputs 0 next cycle; the next valid pair (no sof_i) is index 0.
- Saturation with b=(0,−128), rotated pair.
  - Build with TWIDDLE_TRIVIAL_R22_SAT_EN: y=(−128,0)... for INVERSE=1: yr=127, ovf_o=1.
  - Build without the macro: yr=−128, ovf_o=0.
